vga_sync_gen: RTL and testbench

- Generates 640x480@60 Hz VGA timing (HS, VS, blanking, pixel coordinates) from the 100 MHz system clock.
- Drives the HS/VS inputs of the fractal renderer.
- Produces the per-pixel 16-bit fixed-point complex-plane coordinates (cX, cY) from start/step values, so the renderer, sync and colour output share one timing source.

---
 rtl/vga_sync_gen.sv | 84 ++++++++
 tb/tb_vga_sync_gen.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA sync/blanking timing with per-pixel fixed-point complex-plane coordinates.
// Counters advance once per pixel tick; sync, blanking and coordinates are registered from next-counter values.
module vga_sync_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SW    = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SW    = 2,
  parameter int V_BP    = 33,
  parameter int CLK_DIV = 4
) (
  input  logic        Clk_100M,
  input  logic        reset,
  input  logic [15:0] startX,
  input  logic [15:0] startY,
  input  logic [15:0] stepX,
  input  logic [15:0] stepY,
  output logic        HS,
  output logic        VS,
  output logic        video_on,
  output logic        pix_tick,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        frame_start,
  output logic [15:0] cX,
  output logic [15:0] cY
);
  localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
  localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  logic [DW-1:0] div;
  logic [15:0] start_x_l, start_y_l, step_x_l, step_y_l;
  logic h_wrap, v_wrap, frame_wrap;
  logic [9:0] nx, ny;
  always_comb begin
    h_wrap = pixel_x == 10'(H_TOT - 1);
    v_wrap = pixel_y == 10'(V_TOT - 1);
    frame_wrap = h_wrap && v_wrap;
    nx = h_wrap ? '0 : pixel_x + 10'd1;
    ny = h_wrap ? (v_wrap ? '0 : pixel_y + 10'd1) : pixel_y;
  end
  assign pix_tick = div == DIV_MAX;
  always_ff @(posedge Clk_100M) begin
    if (!reset) begin
      div <= '0;
      pixel_x <= '0;
      pixel_y <= '0;
      HS <= 1'b1;
      VS <= 1'b1;
      video_on <= 1'b1;
      frame_start <= 1'b0;
      start_x_l <= startX;
      start_y_l <= startY;
      step_x_l <= stepX;
      step_y_l <= stepY;
      cX <= startX;
      cY <= startY;
    end else begin
      div <= pix_tick ? '0 : div + DW'(1);
      frame_start <= pix_tick && frame_wrap;
      if (pix_tick) begin
        pixel_x <= nx;
        pixel_y <= ny;
        HS <= !(nx >= 10'(H_VIS + H_FP) && nx < 10'(H_VIS + H_FP + H_SW));
        VS <= !(ny >= 10'(V_VIS + V_FP) && ny < 10'(V_VIS + V_FP + V_SW));
        video_on <= nx < 10'(H_VIS) && ny < 10'(V_VIS);
        if (frame_wrap) begin
          start_x_l <= startX;
          start_y_l <= startY;
          step_x_l <= stepX;
          step_y_l <= stepY;
        end
        // the new frame's start values bypass the latches so column/line 0 use them immediately
        if (h_wrap) cX <= frame_wrap ? startX : start_x_l;
        else if (nx < 10'(H_VIS)) cX <= cX + step_x_l;
        if (frame_wrap) cY <= startY;
        else if (h_wrap && ny < 10'(V_VIS)) cY <= cY + step_y_l;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen: full-size instance for line timing and cX, reduced-geometry instance for frame behaviour.
// An arithmetic reference model (pixel index = clocks/CLK_DIV) checks every output of both instances each cycle.
module tb_vga_sync_gen;
  typedef struct packed {
    logic hs, vs, von, tk, fs;
    logic [9:0] px, py;
    logic [15:0] cx, cy;
  } out_t;
  typedef struct packed { int hv, hf, hs, hb, vv, vf, vs, vb, d; } geom_t;
  typedef struct packed { logic [15:0] sx, sy, tx, ty; } lat_t;
  typedef struct { int sel; int pos; logic [15:0] exp; string nm; } vec_t;

  logic clk = 0;
  logic reset = 0;
  always #5 clk = ~clk;

  logic [15:0] sx0, sy0, tx0, ty0, sx1, sy1, tx1, ty1;
  logic hs0, vs0, von0, tk0, fs0, hs1, vs1, von1, tk1, fs1;
  logic [9:0] px0, py0, px1, py1;
  logic [15:0] cx0, cy0, cx1, cy1;

  vga_sync_gen d0 (
    .Clk_100M(clk), .reset(reset), .startX(sx0), .startY(sy0), .stepX(tx0), .stepY(ty0),
    .HS(hs0), .VS(vs0), .video_on(von0), .pix_tick(tk0), .pixel_x(px0), .pixel_y(py0),
    .frame_start(fs0), .cX(cx0), .cY(cy0)
  );
  vga_sync_gen #(
    .H_VIS(16), .H_FP(2), .H_SW(3), .H_BP(4), .V_VIS(6), .V_FP(2), .V_SW(2), .V_BP(3), .CLK_DIV(4)
  ) d1 (
    .Clk_100M(clk), .reset(reset), .startX(sx1), .startY(sy1), .stepX(tx1), .stepY(ty1),
    .HS(hs1), .VS(vs1), .video_on(von1), .pix_tick(tk1), .pixel_x(px1), .pixel_y(py1),
    .frame_start(fs1), .cX(cx1), .cY(cy1)
  );

  geom_t g0 = '{640, 16, 96, 48, 480, 10, 2, 33, 4};
  geom_t g1 = '{16, 2, 3, 4, 6, 2, 2, 3, 4};
  int errs = 0;
  int checks = 0;
  int c = 0;
  bit run = 0;
  lat_t l0, l1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      if (errs >= 200) begin
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
      end
    end
  endtask

  function automatic out_t model(int cc, geom_t g, lat_t l);
    out_t o;
    int ht, vt, p, x, y, mx, my;
    ht = g.hv + g.hf + g.hs + g.hb;
    vt = g.vv + g.vf + g.vs + g.vb;
    p = cc / g.d;
    x = p % ht;
    y = (p / ht) % vt;
    mx = x < g.hv ? x : g.hv - 1;
    my = y < g.vv ? y : g.vv - 1;
    o.hs = !(x >= g.hv + g.hf && x < g.hv + g.hf + g.hs);
    o.vs = !(y >= g.vv + g.vf && y < g.vv + g.vf + g.vs);
    o.von = x < g.hv && y < g.vv;
    o.tk = (cc % g.d) == g.d - 1;
    o.fs = cc > 0 && cc % g.d == 0 && p % (ht * vt) == 0;
    o.px = 10'(x);
    o.py = 10'(y);
    o.cx = 16'(int'(l.sx) + int'(l.tx) * mx);
    o.cy = 16'(int'(l.sy) + int'(l.ty) * my);
    return o;
  endfunction

  function automatic bit frame_edge(int cc, geom_t g);
    int fr;
    fr = (g.hv + g.hf + g.hs + g.hb) * (g.vv + g.vf + g.vs + g.vb);
    return cc % g.d == 0 && (cc / g.d) % fr == 0;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      c = 0;
      l0 = '{sx0, sy0, tx0, ty0};
      l1 = '{sx1, sy1, tx1, ty1};
    end else begin
      c++;
      if (frame_edge(c, g0)) l0 = '{sx0, sy0, tx0, ty0};
      if (frame_edge(c, g1)) l1 = '{sx1, sy1, tx1, ty1};
    end
  end

  always @(negedge clk) begin
    if (run) begin
      chk("d0 model", 64'({hs0, vs0, von0, tk0, fs0, px0, py0, cx0, cy0}), 64'(model(c, g0, l0)));
      chk("d1 model", 64'({hs1, vs1, von1, tk1, fs1, px1, py1, cx1, cy1}), 64'(model(c, g1, l1)));
    end
  end

  function automatic bit cond(int sel, int a, int b);
    case (sel)
      0: return int'(px0) == a;
      1: return int'(py1) == a;
      2: return int'(hs0) == a;
      3: return int'(vs1) == a;
      4: return int'(py1) == a && int'(px1) == b;
      5: return int'(fs1) == a;
      6: return int'(px1) == a;
      7: return int'(py0) == a;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [15:0] pick(int sel);
    return sel == 0 ? cx0 : sel == 7 ? cy0 : cy1;
  endfunction

  task automatic wait_until(input string nm, input int lim, input int sel, input int a, input int b);
    int n;
    n = 0;
    while (!cond(sel, a, b) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " wait"}, 64'(n < lim), 64'd1);
  endtask

  task automatic chk_reset_vals();
    chk("rst px0", 64'(px0), 0);
    chk("rst py0", 64'(py0), 0);
    chk("rst px1", 64'(px1), 0);
    chk("rst py1", 64'(py1), 0);
    chk("rst hs/vs", 64'({hs0, vs0, hs1, vs1}), 64'hF);
    chk("rst von/tick/fs", 64'({von0, tk0, fs0, von1, tk1, fs1}), 64'b100100);
    chk("rst cx0", 64'(cx0), 64'(sx0));
    chk("rst cy0", 64'(cy0), 64'(sy0));
    chk("rst cx1", 64'(cx1), 64'(sx1));
    chk("rst cy1", 64'(cy1), 64'(sy1));
  endtask

  vec_t tv[9];
  int lo, per, vo, fsn;

  initial begin
    tv[0] = '{0, 1, 16'hE019, "cX px1"};
    tv[1] = '{0, 639, 16'h1E67, "cX px639"};
    tv[2] = '{0, 700, 16'h1E67, "cX px700 hold"};
    tv[3] = '{0, 0, 16'hE000, "cX px0 reload"};
    tv[4] = '{7, 1, 16'hE022, "cY line1"};
    tv[5] = '{1, 1, 16'hE022, "d1 cY line1"};
    tv[6] = '{1, 5, 16'hE0AA, "d1 cY last visible"};
    tv[7] = '{1, 10, 16'hE0AA, "d1 cY vblank hold"};
    tv[8] = '{1, 0, 16'hE000, "d1 cY frame reload"};
    sx0 = 16'hE000; tx0 = 16'h0019; sy0 = 16'hE000; ty0 = 16'h0022;
    sx1 = 16'h1234; tx1 = 16'h0100; sy1 = 16'hE000; ty1 = 16'h0022;
    repeat (10) @(negedge clk);
    run = 1;
    chk_reset_vals();
    reset = 1;
    repeat (2) @(negedge clk);
    chk("tick before 3rd edge", 64'(tk0), 0);
    @(negedge clk);
    chk("tick after 3rd edge", 64'(tk0), 1);
    chk("px before 1st tick", 64'(px0), 0);
    @(negedge clk);
    chk("px after 1st tick", 64'(px0), 1);
    chk("cX after 1st tick", 64'(cx0), 64'hE019);
    for (int i = 0; i < 9; i++) begin
      wait_until(tv[i].nm, 4000, tv[i].sel, tv[i].pos, 0);
      chk(tv[i].nm, 64'(pick(tv[i].sel)), 64'(tv[i].exp));
    end
    wait_until("HS fall", 4000, 2, 0, 0);
    chk("HS fall px", 64'(px0), 656);
    lo = 0; per = 0; vo = 0;
    while (hs0 == 1'b0 && per < 5000) begin lo++; vo += int'(von0); per++; @(negedge clk); end
    while (hs0 == 1'b1 && per < 5000) begin vo += int'(von0); per++; @(negedge clk); end
    chk("HS low clocks", 64'(lo), 384);
    chk("HS period", 64'(per), 3200);
    chk("video_on per line", 64'(vo), 2560);
    wait_until("VS fall", 2000, 3, 0, 0);
    chk("VS fall py/px", 64'({py1, px1}), 64'({10'd8, 10'd0}));
    lo = 0; per = 0; fsn = 0;
    while (vs1 == 1'b0 && per < 3000) begin lo++; fsn += int'(fs1); per++; @(negedge clk); end
    while (vs1 == 1'b1 && per < 3000) begin fsn += int'(fs1); per++; @(negedge clk); end
    chk("VS low clocks", 64'(lo), 200);
    chk("VS period", 64'(per), 1300);
    chk("frame_start per frame", 64'(fsn), 1);
    wait_until("line 3", 2000, 1, 3, 0);
    tx1 = 16'h0001;
    wait_until("line 4 px2", 2000, 4, 4, 2);
    chk("old step mid-frame", 64'(cx1), 64'h1434);
    wait_until("frame_start", 2000, 5, 1, 0);
    wait_until("px2 new frame", 200, 6, 2, 0);
    chk("new step after frame", 64'(cx1), 64'h1236);
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(20, 300)) @(negedge clk);
      {sx1, sy1, tx1, ty1} = {$urandom, $urandom};
      {sx0, sy0, tx0, ty0} = {$urandom, $urandom};
    end
    wait_until("d1 at (10,4)", 2000, 4, 4, 10);
    reset = 0;
    @(negedge clk);
    chk_reset_vals();
    repeat (3) @(negedge clk);
    reset = 1;
    repeat (2000) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
